// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request, issue/hazard and register-file write bundle
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              stall_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1, rs2,
    input  stall_o, we_o, waddr_o, wdata_o, conflict_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1, rs2,
    output stall_o, we_o, waddr_o, wdata_o, conflict_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin register-file write port arbiter with pending-write scoreboard
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic              r_rr_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREGS-1:0]  r_pending;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic              w_both;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_stall;
  logic              w_issue_ready;
  logic              w_issue_fire;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;

  // rr_ptr names the requester that wins the next contested cycle
  assign w_both     = bus.req0_valid & bus.req1_valid;
  assign w_grant0   = bus.req0_valid & (~bus.req1_valid | ~r_rr_ptr);
  assign w_grant1   = bus.req1_valid & (~bus.req0_valid | r_rr_ptr);
  assign w_accept   = w_grant0 | w_grant1;
  assign w_acc_addr = w_grant1 ? bus.req1_addr : bus.req0_addr;
  assign w_acc_data = w_grant1 ? bus.req1_data : bus.req0_data;

  assign w_stall = ((bus.rs1 != '0) & r_pending[bus.rs1]) |
                   ((bus.rs2 != '0) & r_pending[bus.rs2]);
  assign w_issue_ready = ~w_stall & ~((bus.issue_rd != '0) & r_pending[bus.issue_rd]);
  assign w_issue_fire  = bus.issue_valid & w_issue_ready & (bus.issue_rd != '0);

  assign w_set = w_issue_fire ? (NREGS'(1) << bus.issue_rd) : '0;
  assign w_clr = r_we ? (NREGS'(1) << r_waddr) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr       <= 1'b0;
      r_we           <= 1'b0;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_pending      <= '0;
      r_conflict_cnt <= '0;
    end else begin
      // x0 writes are granted but never reach the register file
      r_we <= w_accept & (w_acc_addr != '0);
      if (w_accept && (w_acc_addr != '0)) begin
        r_waddr <= w_acc_addr;
        r_wdata <= w_acc_data;
      end
      if (w_both) begin
        r_rr_ptr <= ~r_rr_ptr;
      end
      if (w_both && (r_conflict_cnt != {CNT_W{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
      // set after clear so a fresh issue of the same register stays outstanding
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.stall_o      = w_stall;
  assign bus.issue_ready  = w_issue_ready;
  assign bus.we_o         = r_we;
  assign bus.waddr_o      = r_waddr;
  assign bus.wdata_o      = r_wdata;
  assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized checks of regfile_write_arbiter against a reference model
module tb_regfile_write_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid  = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid  = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd  = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h1111_1111;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = 32'h2222_2222;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    tick();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd9;
    #1;
    n_total++; if (bus.we_o !== 1'b0) $display("FAIL reset_we got %0b want 0", bus.we_o); else n_pass++;
    n_total++; if (bus.waddr_o !== 5'd0) $display("FAIL reset_waddr got %0d want 0", bus.waddr_o); else n_pass++;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.stall_o); else n_pass++;
    n_total++; if (bus.conflict_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", bus.conflict_cnt); else n_pass++;
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEAD_BEEF;
    #1;
    n_total++; if (bus.req0_ready !== 1'b1) $display("FAIL single_ready got %0b want 1", bus.req0_ready); else n_pass++;
    tick();
    bus.req0_valid = 1'b0;
    n_total++; if (bus.we_o !== 1'b1) $display("FAIL single_we got %0b want 1", bus.we_o); else n_pass++;
    n_total++; if (bus.waddr_o !== 5'd5) $display("FAIL single_waddr got %0d want 5", bus.waddr_o); else n_pass++;
    n_total++; if (bus.wdata_o !== 32'hDEAD_BEEF) $display("FAIL single_wdata got %h want deadbeef", bus.wdata_o); else n_pass++;
    tick();
    n_total++; if (bus.we_o !== 1'b0) $display("FAIL single_we_drop got %0b want 0", bus.we_o); else n_pass++;
    n_total++; if (bus.waddr_o !== 5'd5) $display("FAIL single_waddr_hold got %0d want 5", bus.waddr_o); else n_pass++;
  endtask

  task automatic test_contention();
    logic [AW-1:0] want;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA0A0_0003;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'hB0B0_0007;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (bus.req0_ready !== ((i % 2) == 0)) $display("FAIL cont_ready0[%0d] got %0b want %0b", i, bus.req0_ready, (i % 2) == 0); else n_pass++;
      n_total++; if (bus.req1_ready !== ((i % 2) == 1)) $display("FAIL cont_ready1[%0d] got %0b want %0b", i, bus.req1_ready, (i % 2) == 1); else n_pass++;
      tick();
      want = ((i % 2) == 0) ? 5'd3 : 5'd7;
      n_total++; if (bus.we_o !== 1'b1 || bus.waddr_o !== want) $display("FAIL cont_write[%0d] got we=%0b addr=%0d want we=1 addr=%0d", i, bus.we_o, bus.waddr_o, want); else n_pass++;
    end
    idle();
    n_total++; if (bus.conflict_cnt !== 4'd4) $display("FAIL cont_cnt got %0d want 4", bus.conflict_cnt); else n_pass++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    #1;
    n_total++; if (bus.issue_ready !== 1'b1) $display("FAIL sb_issue_ready got %0b want 1", bus.issue_ready); else n_pass++;
    tick();
    bus.issue_valid = 1'b0;
    #1;
    n_total++; if (bus.issue_ready !== 1'b0) $display("FAIL sb_waw_block got %0b want 0", bus.issue_ready); else n_pass++;
    bus.rs1 = 5'd9;
    #1;
    n_total++; if (bus.stall_o !== 1'b1) $display("FAIL sb_stall_set got %0b want 1", bus.stall_o); else n_pass++;
    tick();
    n_total++; if (bus.stall_o !== 1'b1) $display("FAIL sb_stall_hold got %0b want 1", bus.stall_o); else n_pass++;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h0000_0999;
    tick();
    bus.req1_valid = 1'b0;
    n_total++; if (bus.we_o !== 1'b1 || bus.stall_o !== 1'b1) $display("FAIL sb_stall_at_write got we=%0b stall=%0b want we=1 stall=1", bus.we_o, bus.stall_o); else n_pass++;
    tick();
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL sb_stall_clear got %0b want 0", bus.stall_o); else n_pass++;
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    #1;
    n_total++; if (bus.issue_ready !== 1'b1) $display("FAIL x0_issue_ready got %0b want 1", bus.issue_ready); else n_pass++;
    tick();
    bus.issue_valid = 1'b0;
    #1;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL x0_stall got %0b want 0", bus.stall_o); else n_pass++;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h1234_5678;
    #1;
    n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL x0_ready got %0b want 1", bus.req1_ready); else n_pass++;
    tick();
    bus.req1_valid = 1'b0;
    n_total++; if (bus.we_o !== 1'b0) $display("FAIL x0_we got %0b want 0", bus.we_o); else n_pass++;
    idle();
  endtask

  task automatic test_collision();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    tick();
    bus.issue_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = 32'h0000_0444;
    tick();
    bus.req0_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    #1;
    n_total++; if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'd4) $display("FAIL col_write got we=%0b addr=%0d want we=1 addr=4", bus.we_o, bus.waddr_o); else n_pass++;
    n_total++; if (bus.issue_ready !== 1'b0) $display("FAIL col_block got %0b want 0", bus.issue_ready); else n_pass++;
    tick();
    n_total++; if (bus.issue_ready !== 1'b1) $display("FAIL col_reissue_ready got %0b want 1", bus.issue_ready); else n_pass++;
    tick();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd4;
    #1;
    n_total++; if (bus.stall_o !== 1'b1) $display("FAIL col_pending got %0b want 1", bus.stall_o); else n_pass++;
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h3;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h7;
    tick();
    n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL mid_ptr_flip got %0b want 1", bus.req1_ready); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if (bus.we_o !== 1'b0) $display("FAIL mid_discard got %0b want 0", bus.we_o); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL mid_ptr_reset got r0=%0b r1=%0b want r0=1 r1=0", bus.req0_ready, bus.req1_ready); else n_pass++;
    n_total++; if (bus.conflict_cnt !== 4'd0) $display("FAIL mid_cnt got %0d want 0", bus.conflict_cnt); else n_pass++;
    tick();
    n_total++; if (bus.waddr_o !== 5'd3) $display("FAIL mid_first_write got %0d want 3", bus.waddr_o); else n_pass++;
    idle();
  endtask

  task automatic test_random();
    bit            pend[32];
    int            pref;
    int            cnt;
    int            winner;
    bit            hold0, hold1, e_stall, e_iready, e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic [AW-1:0] last_waddr;
    bit            last_we;
    do_reset();
    foreach (pend[k]) pend[k] = 1'b0;
    pref = 0; cnt = 0; hold0 = 0; hold1 = 0; last_we = 0; last_waddr = '0;
    e_waddr = '0; e_wdata = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_addr  = AW'($urandom_range(0, 7));
        bus.req0_data  = $urandom;
      end
      if (!hold1) begin
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_addr  = AW'($urandom_range(0, 7));
        bus.req1_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_rd    = AW'($urandom_range(0, 7));
      bus.rs1         = AW'($urandom_range(0, 7));
      bus.rs2         = AW'($urandom_range(0, 7));
      #1;
      if (bus.req0_valid && bus.req1_valid) winner = pref;
      else if (bus.req0_valid) winner = 0;
      else if (bus.req1_valid) winner = 1;
      else winner = -1;
      e_stall  = (bus.rs1 != 0 && pend[bus.rs1]) || (bus.rs2 != 0 && pend[bus.rs2]);
      e_iready = !e_stall && !(bus.issue_rd != 0 && pend[bus.issue_rd]);
      n_total++; if (bus.req0_ready !== (winner == 0)) $display("FAIL rnd_ready0[%0d] got %0b want %0b", c, bus.req0_ready, winner == 0); else n_pass++;
      n_total++; if (bus.req1_ready !== (winner == 1)) $display("FAIL rnd_ready1[%0d] got %0b want %0b", c, bus.req1_ready, winner == 1); else n_pass++;
      n_total++; if (bus.stall_o !== e_stall) $display("FAIL rnd_stall[%0d] got %0b want %0b", c, bus.stall_o, e_stall); else n_pass++;
      n_total++; if (bus.issue_ready !== e_iready) $display("FAIL rnd_issue_ready[%0d] got %0b want %0b", c, bus.issue_ready, e_iready); else n_pass++;
      if (last_we) pend[last_waddr] = 1'b0;
      if (bus.issue_valid && e_iready && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
      e_we = 1'b0;
      if (winner == 0 && bus.req0_addr != 0) begin e_we = 1'b1; e_waddr = bus.req0_addr; e_wdata = bus.req0_data; end
      if (winner == 1 && bus.req1_addr != 0) begin e_we = 1'b1; e_waddr = bus.req1_addr; e_wdata = bus.req1_data; end
      if (bus.req0_valid && bus.req1_valid) begin
        pref = 1 - winner;
        if (cnt < CMAX) cnt++;
      end
      hold0 = bus.req0_valid && winner != 0;
      hold1 = bus.req1_valid && winner != 1;
      last_we = e_we; last_waddr = e_waddr;
      tick();
      n_total++; if (bus.we_o !== e_we) $display("FAIL rnd_we[%0d] got %0b want %0b", c, bus.we_o, e_we); else n_pass++;
      if (e_we) begin
        n_total++; if (bus.waddr_o !== e_waddr || bus.wdata_o !== e_wdata) $display("FAIL rnd_write[%0d] got %0d/%h want %0d/%h", c, bus.waddr_o, bus.wdata_o, e_waddr, e_wdata); else n_pass++;
      end
      n_total++; if (bus.conflict_cnt !== CW'(cnt)) $display("FAIL rnd_cnt[%0d] got %0d want %0d", c, bus.conflict_cnt, cnt); else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_x0();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
